// File: rtl/tpu_pkg.sv
// Default operand and accumulator widths shared by every PE in the TPU systolic array.
package tpu_pkg;
   localparam int BITS_AB = 8;
   localparam int BITS_C  = 16;
endpackage

// File: rtl/tpumac_pipereg.sv
// Enabled forwarding register with synchronous active-low reset; carries A/B to neighbouring PEs.
module tpumac_pipereg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // NOTE: non-blocking so every PE in the grid samples its neighbour's pre-edge value.
   always_ff @(posedge clk) begin
      if (!rst_n)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/tpumac.sv
// Signed multiply-accumulate PE: forwards A east and B south, and either preloads or accumulates Cout.
module tpumac #(
   parameter int BITS_AB = tpu_pkg::BITS_AB,
   parameter int BITS_C  = tpu_pkg::BITS_C
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      WrEn,
   input  logic signed [BITS_AB-1:0] Ain,
   input  logic signed [BITS_AB-1:0] Bin,
   input  logic signed [BITS_C-1:0]  Cin,
   output logic signed [BITS_AB-1:0] Aout,
   output logic signed [BITS_AB-1:0] Bout,
   output logic signed [BITS_C-1:0]  Cout
);

   logic signed [2*BITS_AB-1:0] product;
   logic signed [BITS_C-1:0]    product_c;

   tpumac_pipereg #(.WIDTH(BITS_AB)) u_areg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (Ain),
      .q     (Aout)
   );

   tpumac_pipereg #(.WIDTH(BITS_AB)) u_breg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .d     (Bin),
      .q     (Bout)
   );

   // Full-width signed product of the live inputs, then sign-extended or truncated to the accumulator.
   assign product   = Ain * Bin;
   assign product_c = BITS_C'(product);

   // NOTE: Cin is only selected when WrEn is high, so an X on Cin cannot leak into Cout.
   always_ff @(posedge clk) begin
      if (!rst_n)
         Cout <= '0;
      else if (en) begin
         if (WrEn)
            Cout <= Cin;
         else
            Cout <= Cout + product_c;
      end
   end

endmodule

// File: tb/tb_tpumac.sv
// Directed/random bench for tpumac with a reference model feeding an expected-value scoreboard.
module tb_tpumac;

   typedef struct {
      logic signed [7:0]  a;
      logic signed [7:0]  b;
      logic signed [15:0] c;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic              wr_en;
   logic signed [7:0] ain;
   logic signed [7:0] bin;
   logic signed [15:0] cin;
   logic signed [7:0] aout;
   logic signed [7:0] bout;
   logic signed [15:0] cout;

   // Reference state, updated independently of the DUT.
   logic signed [7:0]  m_a;
   logic signed [7:0]  m_b;
   logic signed [15:0] m_c;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   tpumac #(.BITS_AB(8), .BITS_C(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .WrEn  (wr_en),
      .Ain   (ain),
      .Bin   (bin),
      .Cin   (cin),
      .Aout  (aout),
      .Bout  (bout),
      .Cout  (cout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, push the model's expectation, clock, then pop and compare.
   task automatic step(input string tag, input logic r, input logic e, input logic w,
                       input logic signed [7:0] a, input logic signed [7:0] b,
                       input logic signed [15:0] c);
      exp_t got;
      exp_t want;
      int   prod;
      rst_n = r; en = e; wr_en = w; ain = a; bin = b; cin = c;
      if (!r) begin
         m_a = '0; m_b = '0; m_c = '0;
      end else if (e) begin
         m_a = a;
         m_b = b;
         if (w) m_c = c;
         else begin
            prod = int'(a) * int'(b);
            m_c  = 16'(int'(m_c) + prod);
         end
      end
      sb.push_back('{a: m_a, b: m_b, c: m_c});
      @(posedge clk);
      #1;
      got = '{a: aout, b: bout, c: cout};
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         want = sb.pop_front();
         check({tag, ".Aout"}, 16'(got.a), 16'(want.a));
         check({tag, ".Bout"}, 16'(got.b), 16'(want.b));
         check({tag, ".Cout"}, got.c, want.c);
      end
   endtask

   initial begin
      int n;
      logic signed [7:0] ra;
      logic signed [7:0] rb;
      logic signed [15:0] held;

      m_a = '0; m_b = '0; m_c = '0;
      rst_n = 1'b0; en = 1'b1; wr_en = 1'b0; ain = 8'sd5; bin = 8'sd3; cin = 16'sd0;

      // Reset overrides en with live operands on the inputs.
      step("reset0", 1'b0, 1'b1, 1'b0, 8'sd5, 8'sd3, 16'sd0);
      step("reset1", 1'b0, 1'b1, 1'b0, 8'sd5, 8'sd3, 16'sd0);
      check("reset.Cout_zero", cout, 16'h0000);

      // Load, then hold with X on every data/control input except en.
      step("load", 1'b1, 1'b1, 1'b1, 8'sd7, -8'sd2, 16'sd100);
      check("load.Cout_100", cout, 16'd100);
      step("hold", 1'b1, 1'b0, 1'bx, 8'hxx, 8'hxx, 16'hxxxx);

      // Single MAC on live inputs: 100 + (-3*4) = 88 (86 would mean registered operands were used).
      step("mac1", 1'b1, 1'b1, 1'b0, -8'sd3, 8'sd4, 16'hxxxx);
      check("mac1.Cout_88", cout, 16'd88);

      // Random accumulates interleaved with disabled cycles.
      n = $urandom_range(15, 1);
      for (int i = 0; i < n; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         step("rand_mac", 1'b1, 1'b1, 1'b0, ra, rb, 16'hxxxx);
         held = cout;
         step("rand_hold", 1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 16'($urandom));
         check("rand_hold.stable", cout, held);
      end

      // Extremes and modular wrap.
      step("ext_load", 1'b1, 1'b1, 1'b1, 8'sd0, 8'sd0, 16'sd32767);
      step("ext_m128sq", 1'b1, 1'b1, 1'b0, -8'sd128, -8'sd128, 16'hxxxx);
      check("ext.Cout_BFFF", cout, 16'hBFFF);
      step("ext_127sq", 1'b1, 1'b1, 1'b0, 8'sd127, 8'sd127, 16'hxxxx);
      step("ext_m128x127", 1'b1, 1'b1, 1'b0, -8'sd128, 8'sd127, 16'hxxxx);
      step("ext_m128x127b", 1'b1, 1'b1, 1'b0, -8'sd128, 8'sd127, 16'hxxxx);
      step("ext_127sq_b", 1'b1, 1'b1, 1'b0, 8'sd127, 8'sd127, 16'hxxxx);

      // Reset in the middle of an accumulate run, then restart from zero.
      step("mid_mac0", 1'b1, 1'b1, 1'b0, 8'sd11, 8'sd13, 16'hxxxx);
      step("mid_mac1", 1'b1, 1'b1, 1'b0, -8'sd9, 8'sd7, 16'hxxxx);
      step("mid_rst", 1'b0, 1'b1, 1'b0, 8'sd9, 8'sd9, 16'hxxxx);
      check("mid_rst.Cout_zero", cout, 16'h0000);
      step("restart", 1'b1, 1'b1, 1'b0, 8'sd2, 8'sd3, 16'hxxxx);
      check("restart.Cout_6", cout, 16'd6);

      // Long disabled stretch must not decay.
      for (int i = 0; i < 5; i++)
         step("long_hold", 1'b1, 1'b0, 1'b1, 8'sd1, 8'sd1, 16'sd1234);
      check("long_hold.Cout_6", cout, 16'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
